// File: rtl/hand_bbox_centroid_pkg.sv
// hand_bbox_centroid_pkg: frame geometry, field widths, FSM states and accumulator record.
// CENTROID_EN adds the coordinate sums to the accumulator record.
package hand_bbox_centroid_pkg;
  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 480;
  localparam int DEF_MIN_AREA = 64;
  localparam int CW = 9;
  localparam int AW = 18;
  localparam int SXW = 26;
  localparam int SYW = 27;
  typedef enum logic [2:0] {IDLE, SNAP, DIV_X, DIV_Y, HOLD} state_e;
  typedef struct packed {
    logic [AW-1:0] area;
    logic [CW-1:0] xmin;
    logic [CW-1:0] xmax;
    logic [CW-1:0] ymin;
    logic [CW-1:0] ymax;
`ifdef CENTROID_EN
    logic [SXW-1:0] sx;
    logic [SYW-1:0] sy;
`endif
  } acc_t;
  function automatic acc_t acc_init();
    acc_t a;
    a = '0;
    a.xmin = '1;
    a.ymin = '1;
    return a;
  endfunction
endpackage

// File: rtl/hand_bbox_centroid_if.sv
// hand_bbox_centroid_if: result record with valid/ready handshake and overwrite pulse.
interface hand_bbox_centroid_if;
  import hand_bbox_centroid_pkg::*;
  logic res_valid;
  logic res_ready;
  logic res_found;
  logic res_drop;
  logic [AW-1:0] res_area;
  logic [CW-1:0] res_xmin;
  logic [CW-1:0] res_xmax;
  logic [CW-1:0] res_ymin;
  logic [CW-1:0] res_ymax;
  logic [CW-1:0] res_cx;
  logic [CW-1:0] res_cy;
  modport master (
    output res_valid, res_found, res_drop, res_area, res_xmin, res_xmax, res_ymin, res_ymax,
           res_cx, res_cy,
    input  res_ready
  );
  modport slave (
    input  res_valid, res_found, res_drop, res_area, res_xmin, res_xmax, res_ymin, res_ymax,
           res_cx, res_cy,
    output res_ready
  );
endinterface

// File: rtl/hand_bbox_centroid_seq_divider.sv
// seq_divider: 27-step restoring divider, 9-bit quotient saturating at 511.
// Present only when CENTROID_EN is defined.
`ifdef CENTROID_EN
module seq_divider
  import hand_bbox_centroid_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [SYW-1:0] dividend_i,
  input  logic [AW-1:0]  divisor_i,
  output logic           done_o,
  output logic [CW-1:0]  quo_o
);
  logic [SYW-1:0] q_q, q_in, q_s;
  logic [AW-1:0] r_q, r_in, r_s;
  logic [AW:0] sh;
  logic [4:0] cnt_q;
  logic run_q, ge;
  // the start cycle already performs the first step, so 27 steps end 27 clocks later
  always_comb begin
    q_in = start_i ? dividend_i : q_q;
    r_in = start_i ? '0 : r_q;
    sh = {r_in, q_in[SYW-1]};
    ge = sh >= {1'b0, divisor_i};
    r_s = ge ? AW'(sh - {1'b0, divisor_i}) : sh[AW-1:0];
    q_s = {q_in[SYW-2:0], ge};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_q <= '0;
      r_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      run_q <= start_i || (run_q && cnt_q != 5'd0);
      if (start_i || (run_q && cnt_q != 5'd0)) begin
        q_q <= q_s;
        r_q <= r_s;
        cnt_q <= start_i ? 5'd26 : cnt_q - 5'd1;
      end
    end
  assign done_o = run_q && cnt_q == 5'd0;
  assign quo_o = |q_q[SYW-1:CW] ? '1 : q_q[CW-1:0];
endmodule
`endif

// File: rtl/hand_bbox_centroid.sv
// hand_bbox_centroid: per-frame area, bounding box and (CENTROID_EN) centroid of the
// foreground pixel stream, presented as one valid/ready record per complete frame.
module hand_bbox_centroid
  import hand_bbox_centroid_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int MIN_AREA = DEF_MIN_AREA
) (
  input  logic guass_clk,
  input  logic rst_n,
  input  logic CMOS_VSYNC,
  input  logic data_me,
  hand_bbox_centroid_if.master res
);
  state_e state_q, state_d;
  acc_t acc_q, acc_d, hold_q;
  logic [CW-1:0] x_q, y_q;
  logic done_q, fc_q, drop_q, found, pix, x_end, last, snap;
  assign pix = !CMOS_VSYNC && !done_q;
  assign x_end = x_q == CW'(IMG_W - 1);
  assign last = x_end && y_q == CW'(IMG_H - 1);
  assign snap = fc_q && (state_q == IDLE || state_q == HOLD);
  assign found = hold_q.area >= AW'(MIN_AREA);
  // done_q freezes the counters after the last pixel until the next blanking
  always_ff @(posedge guass_clk or negedge rst_n)
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      done_q <= 1'b0;
      fc_q <= 1'b0;
    end else begin
      fc_q <= pix && last;
      if (CMOS_VSYNC) begin
        x_q <= '0;
        y_q <= '0;
        done_q <= 1'b0;
      end else if (!done_q) begin
        x_q <= last ? x_q : (x_end ? '0 : x_q + 1'b1);
        y_q <= (x_end && !last) ? y_q + 1'b1 : y_q;
        done_q <= last;
      end
    end
  always_comb begin
    acc_d = acc_q;
    if (CMOS_VSYNC || fc_q) acc_d = acc_init();
    else if (pix && data_me) begin
      acc_d.area = acc_q.area + 1'b1;
      acc_d.xmin = x_q < acc_q.xmin ? x_q : acc_q.xmin;
      acc_d.xmax = x_q > acc_q.xmax ? x_q : acc_q.xmax;
      acc_d.ymin = y_q < acc_q.ymin ? y_q : acc_q.ymin;
      acc_d.ymax = y_q > acc_q.ymax ? y_q : acc_q.ymax;
`ifdef CENTROID_EN
      acc_d.sx = acc_q.sx + SXW'(x_q);
      acc_d.sy = acc_q.sy + SYW'(y_q);
`endif
    end
  end
  always_ff @(posedge guass_clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= acc_init();
      hold_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      if (snap) hold_q <= acc_q;
      drop_q <= state_q == HOLD && fc_q && !res.res_ready;
    end
`ifdef CENTROID_EN
  logic div_start, div_done;
  logic [CW-1:0] quo, cx_q, cy_q;
  seq_divider u_div (
    .clk(guass_clk),
    .rst_n,
    .start_i(div_start),
    .dividend_i(state_q == SNAP ? SYW'(hold_q.sx) : hold_q.sy),
    .divisor_i(hold_q.area),
    .done_o(div_done),
    .quo_o(quo)
  );
  always_ff @(posedge guass_clk or negedge rst_n)
    if (!rst_n) begin
      cx_q <= '0;
      cy_q <= '0;
    end else if (snap) begin
      cx_q <= '0;
      cy_q <= '0;
    end else if (div_done && state_q == DIV_X) cx_q <= quo;
    else if (div_done && state_q == DIV_Y) cy_q <= quo;
  assign res.res_cx = cx_q;
  assign res.res_cy = cy_q;
`else
  assign res.res_cx = '0;
  assign res.res_cy = '0;
`endif
  // a frame completing during DIV_* is ignored; in HOLD it replaces the record
  always_comb begin
    state_d = state_q;
`ifdef CENTROID_EN
    div_start = 1'b0;
`endif
    case (state_q)
      IDLE: state_d = fc_q ? SNAP : IDLE;
`ifdef CENTROID_EN
      SNAP: begin
        state_d = found ? DIV_X : HOLD;
        div_start = found;
      end
      DIV_X: begin
        state_d = div_done ? DIV_Y : DIV_X;
        div_start = div_done;
      end
      DIV_Y: state_d = div_done ? HOLD : DIV_Y;
`else
      SNAP: state_d = HOLD;
`endif
      HOLD: state_d = fc_q ? SNAP : (res.res_ready ? IDLE : HOLD);
      default: state_d = IDLE;
    endcase
  end
  assign res.res_valid = state_q == HOLD;
  assign res.res_found = found;
  assign res.res_drop = drop_q;
  assign res.res_area = hold_q.area;
  assign res.res_xmin = found ? hold_q.xmin : '0;
  assign res.res_xmax = found ? hold_q.xmax : '0;
  assign res.res_ymin = found ? hold_q.ymin : '0;
  assign res.res_ymax = found ? hold_q.ymax : '0;
endmodule

// File: tb/tb_hand_bbox_centroid.sv
// tb_hand_bbox_centroid: directed frames on a 40x30 image with hand-computed records.
module tb_hand_bbox_centroid;
  localparam int W = 40;
  localparam int H = 30;
`ifdef CENTROID_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vsync = 1'b1;
  logic data = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  hand_bbox_centroid_if res_if();
  hand_bbox_centroid #(.IMG_W(W), .IMG_H(H), .MIN_AREA(64)) dut (
    .guass_clk(clk),
    .rst_n(rst_n),
    .CMOS_VSYNC(vsync),
    .data_me(data),
    .res(res_if)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drives one frame from a negedge; returns at the negedge after the last pixel is sampled
  task automatic frame(input int x0, input int x1, input int y0, input int y1, input int cut);
    vsync = 1'b1;
    data = 1'b0;
    repeat (3) @(negedge clk);
    for (int p = 0; p < W * H; p++) begin
      if (p == cut) begin
        vsync = 1'b1;
        data = 1'b0;
        return;
      end
      vsync = 1'b0;
      data = (p % W >= x0 && p % W <= x1 && p / W >= y0 && p / W <= y1);
      @(negedge clk);
    end
    vsync = 1'b1;
    data = 1'b0;
  endtask

  task automatic rec(input string tag, input int area, input int xn, input int xx, input int yn,
                     input int yx, input int cx, input int cy, input int drops_exp);
    int lat, drops;
    bit f;
    lat = 0;
    drops = 0;
    do begin
      @(negedge clk);
      lat++;
      drops += int'(res_if.res_drop);
    end while (!res_if.res_valid && lat < 300);
    f = area >= 64;
    check({tag, ".lat"}, lat, (f && CEN) ? 56 : 2);
    check({tag, ".drop"}, drops, drops_exp);
    check({tag, ".found"}, int'(res_if.res_found), int'(f));
    check({tag, ".area"}, int'(res_if.res_area), area);
    check({tag, ".xmin"}, int'(res_if.res_xmin), f ? xn : 0);
    check({tag, ".xmax"}, int'(res_if.res_xmax), f ? xx : 0);
    check({tag, ".ymin"}, int'(res_if.res_ymin), f ? yn : 0);
    check({tag, ".ymax"}, int'(res_if.res_ymax), f ? yx : 0);
    check({tag, ".cx"}, int'(res_if.res_cx), (f && CEN) ? cx : 0);
    check({tag, ".cy"}, int'(res_if.res_cy), (f && CEN) ? cy : 0);
  endtask

  task automatic accept(input string tag);
    repeat (3) @(negedge clk);
    check({tag, ".held"}, int'(res_if.res_valid), 1);
    res_if.res_ready = 1'b1;
    @(negedge clk);
    check({tag, ".ack"}, int'(res_if.res_valid), 0);
    res_if.res_ready = 1'b0;
  endtask

  initial begin
    int v;
    res_if.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.valid", int'(res_if.res_valid), 0);
    check("rst.drop", int'(res_if.res_drop), 0);
    check("rst.area", int'(res_if.res_area), 0);
    check("rst.found", int'(res_if.res_found), 0);
    rst_n = 1'b1;
    @(negedge clk);
    frame(1, 0, 0, -1, -1);
    rec("zero", 0, 0, 0, 0, 0, 0, 0, 0);
    accept("zero");
    frame(10, 19, 5, 14, -1);
    rec("sq10", 100, 10, 19, 5, 14, 14, 9, 0);
    accept("sq10");
    frame(0, 4, 0, 4, -1);
    rec("sq5", 25, 0, 4, 0, 4, 2, 2, 0);
    accept("sq5");
    frame(32, 39, 22, 29, -1);
    rec("corner", 64, 32, 39, 22, 29, 35, 25, 0);
    accept("corner");
    frame(10, 19, 5, 14, 1000);
    v = 0;
    repeat (100) begin
      @(negedge clk);
      v += int'(res_if.res_valid) + int'(res_if.res_drop);
    end
    check("cut.norec", v, 0);
    frame(10, 19, 5, 14, -1);
    rec("aftercut", 100, 10, 19, 5, 14, 14, 9, 0);
    accept("aftercut");
    frame(10, 19, 5, 14, -1);
    rec("dropA", 100, 10, 19, 5, 14, 14, 9, 0);
    frame(20, 27, 3, 11, -1);
    rec("dropB", 72, 20, 27, 3, 11, 23, 7, 1);
    accept("dropB");
    frame(10, 19, 5, 14, -1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst.valid", int'(res_if.res_valid), 0);
    check("midrst.area", int'(res_if.res_area), 0);
    check("midrst.found", int'(res_if.res_found), 0);
    check("midrst.xmax", int'(res_if.res_xmax), 0);
    rst_n = 1'b1;
    @(negedge clk);
    frame(10, 19, 5, 14, -1);
    rec("postrst", 100, 10, 19, 5, 14, 14, 9, 0);
    accept("postrst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
